// File: rtl/draw_pkg.sv
// Shared types for the draw scheduler: command bundle, FSM states,
// and default screen geometry.
package draw_pkg;

   localparam int DEF_SCREEN_W = 160;
   localparam int DEF_SCREEN_H = 120;

   typedef struct packed {
      logic [2:0] colour;
      logic [7:0] cx;
      logic [6:0] cy;
      logic [7:0] diam;
   } draw_cmd_t;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ARM,
      RUN,
      RELEASE,
      CLEAR
   } sched_state_e;

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO holding pending draw commands.
// Caller guarantees no push when full and no pop when empty.
module cmd_fifo
   import draw_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      push,
   input  draw_cmd_t wdata,
   input  logic      pop,
   output draw_cmd_t rdata,
   output logic      full,
   output logic      empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   draw_cmd_t     mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/draw_scheduler.sv
// Queues draw commands and sequences one shape engine per command.
// Define SCREEN_CLEAR_EN to sweep the screen to black after reset.
module draw_scheduler
   import draw_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int SCREEN_W   = DEF_SCREEN_W,
   parameter int SCREEN_H   = DEF_SCREEN_H
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_colour,
   input  logic [7:0] cmd_cx,
   input  logic [6:0] cmd_cy,
   input  logic [7:0] cmd_diam,
   output logic       eng_rst_n,
   output logic       eng_start,
   output logic [2:0] eng_colour,
   output logic [7:0] eng_cx,
   output logic [6:0] eng_cy,
   output logic [7:0] eng_diam,
   input  logic       eng_done,
   input  logic [7:0] eng_x,
   input  logic [6:0] eng_y,
   input  logic [2:0] eng_pcolour,
   input  logic       eng_plot,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       vga_plot,
   output logic       busy,
   output logic [7:0] jobs_done
);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
       SCREEN_W > 256 || SCREEN_H > 128) begin : g_bad_cfg
      $error("draw_scheduler: unsupported parameters");
   end

   sched_state_e state;
   sched_state_e state_nx;
   draw_cmd_t    head;
   draw_cmd_t    cmd_q;
   logic         full;
   logic         empty;
   logic         push;
   logic         pop;

   assign cmd_ready = rst_n & ~full;
   assign push      = cmd_valid & cmd_ready;
   assign pop       = (state == LOAD);

   cmd_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata ({cmd_colour, cmd_cx, cmd_cy, cmd_diam}),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );

`ifdef SCREEN_CLEAR_EN
   localparam sched_state_e RST_STATE = CLEAR;

   logic [7:0] clr_x;
   logic [6:0] clr_y;
   logic       clr_x_end;
   logic       clr_last;

   assign clr_x_end = (clr_x == 8'(SCREEN_W - 1));
   assign clr_last  = clr_x_end && (clr_y == 7'(SCREEN_H - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         clr_x <= '0;
         clr_y <= '0;
      end else if (state == CLEAR) begin
         if (clr_x_end) begin
            clr_x <= '0;
            clr_y <= clr_y + 7'd1;
         end else begin
            clr_x <= clr_x + 8'd1;
         end
      end
   end
`else
   localparam sched_state_e RST_STATE = IDLE;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= RST_STATE;
         cmd_q     <= '0;
         jobs_done <= '0;
      end else begin
         state <= state_nx;
         if (state == LOAD) cmd_q <= head;
         if (state == RUN && eng_done) jobs_done <= jobs_done + 8'd1;
      end
   end

   // Engine stays in reset outside RUN/RELEASE so a stale job never plots.
   always_comb begin
      state_nx   = state;
      eng_rst_n  = 1'b0;
      eng_start  = 1'b0;
      vga_plot   = 1'b0;
      vga_x      = eng_x;
      vga_y      = eng_y;
      vga_colour = eng_pcolour;
      unique case (state)
         IDLE: begin
            if (!empty) state_nx = LOAD;
         end
         LOAD: begin
            state_nx = ARM;
         end
         ARM: begin
            state_nx = RUN;
         end
         RUN: begin
            eng_rst_n = 1'b1;
            eng_start = 1'b1;
            vga_plot  = eng_plot;
            if (eng_done) state_nx = RELEASE;
         end
         RELEASE: begin
            eng_rst_n = 1'b1;
            state_nx  = empty ? IDLE : LOAD;
         end
`ifdef SCREEN_CLEAR_EN
         CLEAR: begin
            vga_plot   = 1'b1;
            vga_x      = clr_x;
            vga_y      = clr_y;
            vga_colour = 3'd0;
            if (clr_last) state_nx = IDLE;
         end
`endif
         default: begin
            state_nx = RST_STATE;
         end
      endcase
   end

   assign busy       = !(state == IDLE && empty);
   assign eng_colour = cmd_q.colour;
   assign eng_cx     = cmd_q.cx;
   assign eng_cy     = cmd_q.cy;
   assign eng_diam   = cmd_q.diam;

endmodule

// File: tb/tb_draw_scheduler.sv
// Randomised bench for draw_scheduler against a job-timeline model.
// Build with SCREEN_CLEAR_EN to cover the post-reset screen sweep.
module tb_draw_scheduler;
   import draw_pkg::*;

   localparam int DEPTH = 4;
   localparam int NPIX  = 160 * 120;
`ifdef SCREEN_CLEAR_EN
   localparam bit CLR_EN = 1'b1;
`else
   localparam bit CLR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [2:0] cmd_colour = '0;
   logic [7:0] cmd_cx = '0;
   logic [6:0] cmd_cy = '0;
   logic [7:0] cmd_diam = '0;
   logic       eng_rst_n;
   logic       eng_start;
   logic [2:0] eng_colour;
   logic [7:0] eng_cx;
   logic [6:0] eng_cy;
   logic [7:0] eng_diam;
   logic       eng_done = 1'b0;
   logic [7:0] eng_x = '0;
   logic [6:0] eng_y = '0;
   logic [2:0] eng_pcolour = '0;
   logic       eng_plot = 1'b0;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot;
   logic       busy;
   logic [7:0] jobs_done;

   always #5 clk = ~clk;

   draw_scheduler #(
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_colour  (cmd_colour),
      .cmd_cx      (cmd_cx),
      .cmd_cy      (cmd_cy),
      .cmd_diam    (cmd_diam),
      .eng_rst_n   (eng_rst_n),
      .eng_start   (eng_start),
      .eng_colour  (eng_colour),
      .eng_cx      (eng_cx),
      .eng_cy      (eng_cy),
      .eng_diam    (eng_diam),
      .eng_done    (eng_done),
      .eng_x       (eng_x),
      .eng_y       (eng_y),
      .eng_pcolour (eng_pcolour),
      .eng_plot    (eng_plot),
      .vga_x       (vga_x),
      .vga_y       (vga_y),
      .vga_colour  (vga_colour),
      .vga_plot    (vga_plot),
      .busy        (busy),
      .jobs_done   (jobs_done)
   );

   // A job: accepted at edge acc, runs from edge s for lat+1 cycles.
   typedef struct {
      draw_cmd_t cmd;
      int        acc;
      int        s;
      int        lat;
   } job_t;

   job_t      jobs[$];
   int        cyc = 0;
   int        clr_base = 0;
   bit        armed = 1'b0;
   bit        rst_req = 1'b1;
   bit        want_valid = 1'b0;
   draw_cmd_t want_cmd = '0;
   int        next_lat = 0;
   bit        accepted = 1'b0;
   bit        plot_all = 1'b1;
   bit        prev_start = 1'b0;
   int        seen_cx[$];
   int        n_vec = 0;
   int        n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h",
                  tag, cyc, got, exp);
      end
   endtask

   function automatic bit in_clear(input int t);
      return CLR_EN && armed && (t - clr_base) < NPIX;
   endfunction

   function automatic void model_eval(
      input  int        t,
      output bit        run,
      output bit        rel,
      output bit        win,
      output int        occ,
      output int        ncomp,
      output draw_cmd_t cur,
      output int        ri
   );
      run = 0; rel = 0; win = 0;
      occ = 0; ncomp = 0; cur = '0; ri = 0;
      foreach (jobs[j]) begin
         int e;
         e = jobs[j].s + jobs[j].lat;
         if (jobs[j].acc <= t && t < jobs[j].s - 1) occ++;
         if (jobs[j].s - 1 <= t) cur = jobs[j].cmd;
         if (t >= jobs[j].s && t <= e) begin
            run = 1;
            ri  = j;
         end
         if (t == e + 1) rel = 1;
         if (t >= jobs[j].s - 2 && t <= e + 1) win = 1;
         if (t > e) ncomp++;
      end
   endfunction

   task automatic tick();
      bit        run, rel, win, clr, rdy, acc;
      int        occ, ncomp, ri, k, fl, pe;
      draw_cmd_t cur;
      job_t      nj;
      @(negedge clk);
      rst_n = !rst_req;
      model_eval(cyc, run, rel, win, occ, ncomp, cur, ri);
      clr = in_clear(cyc);
      k   = cyc - clr_base;
      rdy = rst_n && occ < DEPTH;
      cmd_valid = want_valid;
      {cmd_colour, cmd_cx, cmd_cy, cmd_diam} =
         want_valid ? want_cmd : 26'($urandom);
      eng_x       = 8'($urandom);
      eng_y       = 7'($urandom);
      eng_pcolour = 3'($urandom);
      eng_plot    = plot_all ? 1'b1 : 1'($urandom);
      eng_done    = run ? (cyc == jobs[ri].s + jobs[ri].lat)
                        : ($urandom_range(0, 7) == 0);
      #1;
      if (armed) begin
         chk("cmd_ready", cmd_ready, rdy);
         chk("eng_start", eng_start, run);
         chk("eng_rst_n", eng_rst_n, run || rel);
         chk("vga_plot", vga_plot, run ? eng_plot : clr);
         if (run && eng_plot)
            chk("vga_pix", {vga_x, vga_y, vga_colour},
                {eng_x, eng_y, eng_pcolour});
         if (clr)
            chk("clr_pix", {vga_x, vga_y, vga_colour},
                {8'(k % 160), 7'(k / 160), 3'd0});
         chk("eng_cmd", {eng_colour, eng_cx, eng_cy, eng_diam}, cur);
         chk("jobs_done", jobs_done, ncomp % 256);
         chk("busy", busy, win || occ > 0 || clr);
         if (eng_start && !prev_start) seen_cx.push_back(int'(eng_cx));
         prev_start = eng_start;
      end
      acc = rdy && want_valid;
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
         jobs.delete();
         armed    = 1'b1;
         clr_base = cyc;
      end else if (acc) begin
         fl = CLR_EN ? clr_base + NPIX + 3 : 0;
         pe = jobs.size() > 0 ? jobs[$].s + jobs[$].lat + 4 : 0;
         nj.cmd = want_cmd;
         nj.acc = cyc;
         nj.lat = next_lat;
         nj.s   = cyc + 3;
         if (pe > nj.s) nj.s = pe;
         if (fl > nj.s) nj.s = fl;
         jobs.push_back(nj);
         accepted = 1'b1;
      end
   endtask

   task automatic send(input draw_cmd_t c, input int lat);
      want_cmd   = c;
      next_lat   = lat;
      want_valid = 1'b1;
      accepted   = 1'b0;
      for (int n = 0; n < 30000 && !accepted; n++) tick();
      want_valid = 1'b0;
      chk("push_accepted", accepted, 1'b1);
   endtask

   task automatic wait_idle(input string tag);
      bit        run, rel, win, ok;
      int        occ, ncomp, ri;
      draw_cmd_t cur;
      ok = 1'b0;
      for (int n = 0; n < 40000 && !ok; n++) begin
         model_eval(cyc, run, rel, win, occ, ncomp, cur, ri);
         if (!win && occ == 0 && !in_clear(cyc)) ok = 1'b1;
         else tick();
      end
      chk(tag, ok, 1'b1);
   endtask

   initial begin
      draw_cmd_t c;
      int        idx;

      // reset, then one directed job with a 100-cycle engine
      rst_req = 1'b1;
      repeat (2) tick();
      rst_req = 1'b0;
      tick();
      send('{colour: 3'b010, cx: 8'd80, cy: 7'd60, diam: 8'd40}, 100);
      wait_idle("idle_first");
      tick();
      #2 chk("first_jobs", jobs_done, 8'd1);

      // queue fills behind a long job; order must be preserved
      seen_cx.delete();
      send('{colour: 3'd1, cx: 8'd5, cy: 7'd5, diam: 8'd5}, 60);
      for (int i = 1; i <= 5; i++) begin
         c    = draw_cmd_t'(26'($urandom));
         c.cx = 8'(10 * i);
         send(c, 3);
      end
      wait_idle("idle_order");
      chk("order_n", seen_cx.size(), 6);
      for (int i = 1; i <= 5; i++)
         if (i < seen_cx.size()) chk("order_cx", seen_cx[i], 10 * i);
      tick();
      #2 chk("order_jobs", jobs_done, 8'd7);

      // random traffic with random engine latency and plot strobes
      plot_all = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 1) == 1)
            send(draw_cmd_t'(26'($urandom)), $urandom_range(0, 15));
         else
            repeat ($urandom_range(1, 6)) tick();
      end
      wait_idle("idle_rand");
      plot_all = 1'b1;

      // reset five cycles into RUN with two commands still queued
      idx = jobs.size();
      for (int i = 0; i < 3; i++)
         send(draw_cmd_t'(26'($urandom)), 50);
      for (int n = 0; n < 200 && cyc < jobs[idx].s + 5; n++) tick();
      rst_req = 1'b1;
      tick();
      rst_req = 1'b0;
      #2;
      chk("abort_start", eng_start, 1'b0);
      chk("abort_plot", vga_plot, CLR_EN);
      chk("abort_jobs", jobs_done, 8'd0);
      chk("abort_busy", busy, CLR_EN);
      tick();
      wait_idle("idle_abort");

      // 256 zero-latency jobs wrap the counter back to zero
      for (int i = 0; i < 256; i++)
         send(draw_cmd_t'(26'($urandom)), 0);
      wait_idle("idle_wrap");
      tick();
      #2 chk("wrap_jobs", jobs_done, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
